// File: rtl/pipelined_controller_pkg.sv
// Shared decode constants, select encodings and the ID->EX control bundle
// for the 19-bit pipelined controller.
// Pure declarations: no logic, no latency, no flow control.
package pipelined_controller_pkg;

  // Opcode field is the top 6 bits of the instruction word.
  localparam int OP_W = 6;

  // Opcode classes, matched against the leading bits of the opcode field.
  localparam logic [2:0] OP3_MEM    = 3'b100;
  localparam logic [2:0] OP3_BRANCH = 3'b101;
  localparam logic [2:0] OP3_SHIFT  = 3'b110;
  localparam logic [4:0] OP5_JMP    = 5'b11100;
  localparam logic [4:0] OP5_JSB    = 5'b11101;
  localparam logic [5:0] OP6_RET    = 6'b111100;

  // Next-PC select.
  typedef enum logic [1:0] {
    PC_INC    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_RET    = 2'b11
  } pc_mux_e;

  // Register-file write-data select.
  localparam logic [1:0] WR_ALU   = 2'b00;
  localparam logic [1:0] WR_SHIFT = 2'b01;
  localparam logic [1:0] WR_MEM   = 2'b10;

  // ALU operand select used for address generation on LDM/STM.
  localparam logic [1:0] AIN_MEM = 2'b01;

  // Control bundle registered into EX. write_c/write_z/flag_sh are internal:
  // they steer the flag register one cycle after decode.
  typedef struct packed {
    logic       mem_write;
    logic       reg_write;
    logic       reg_b_mux;
    logic       alu_use_carry;
    logic [2:0] alu_op;
    logic [1:0] alu_in_mux;
    logic [1:0] reg_write_mux;
    logic       write_c;
    logic       write_z;
    logic       flag_sh;   // 1: flags come from the shifter, 0: from the ALU
  } ex_ctrl_t;

endpackage

// File: rtl/pipelined_controller_return_stack.sv
// Return-address LIFO for JSB/RET with sticky overflow/underflow flags.
// top is combinational from current contents; push/pop take effect at the clock edge.
// No backpressure: push when full is dropped (ovf), pop when empty is ignored (unf).
//
// Ports: clk, reset (async active-low), push/push_dat, pop,
//        top (0 when empty), full, empty, ovf, unf (sticky until reset).
module pipelined_controller_return_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty,
  output logic         ovf,
  output logic         unf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // cnt holds the number of live entries (0..DEPTH), hence one extra bit.
  logic [CW-1:0] cnt;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] top_idx;

  assign wr_idx  = cnt[AW-1:0];
  // When full, wr_idx wraps to 0 and top_idx lands on DEPTH-1 as required.
  assign top_idx = wr_idx - AW'(1);
  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign top     = empty ? '0 : mem[top_idx];

  // Storage needs no reset: entries are only visible below cnt.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (push) begin
        if (full) begin
          ovf <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else if (pop) begin
        if (empty) begin
          unf <= 1'b1;
        end else begin
          cnt <= cnt - CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pipelined_controller.sv
// ID-stage control unit: decodes, resolves redirects, owns C/Z flags and the return stack.
// Control bundle reaches EX one cycle after decode; pc_mux/target/stall/flush are combinational.
// Stalls ID for one cycle when a branch follows a flag-writing instruction; no other backpressure.
//
// Ports: clk, reset (async active-low); id_valid/id_instr/id_pc from IF/ID;
//        alu_c/alu_z, sh_c/sh_z EX results; pc_mux/target/id_stall/if_flush to fetch;
//        ex_* registered control bundle; flag_c/flag_z; stk_ovf/stk_unf sticky.
module pipelined_controller
  import pipelined_controller_pkg::*;
#(
  parameter int INSTR_W     = 19,
  parameter int PC_W        = 12,
  parameter int STACK_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [INSTR_W-1:0] id_instr,
  input  logic [PC_W-1:0]    id_pc,
  input  logic               alu_c,
  input  logic               alu_z,
  input  logic               sh_c,
  input  logic               sh_z,
  output logic [1:0]         pc_mux,
  output logic [PC_W-1:0]    target,
  output logic               id_stall,
  output logic               if_flush,
  output logic               ex_mem_write,
  output logic               ex_reg_write,
  output logic               ex_reg_B_mux,
  output logic               ex_alu_use_carry,
  output logic [2:0]         ex_alu_op,
  output logic [1:0]         ex_alu_in_mux,
  output logic [1:0]         ex_reg_write_mux,
  output logic               flag_c,
  output logic               flag_z,
  output logic               stk_ovf,
  output logic               stk_unf
);

  logic [OP_W-1:0] op6;
  logic            is_arith;
  logic            is_mem;
  logic            is_shift;
  logic            is_branch;
  logic            is_jmp;
  logic            is_jsb;
  logic            is_ret;
  logic            issue;
  logic            br_cond;
  logic            br_taken;
  pc_mux_e         pc_sel;
  ex_ctrl_t        ex_d;
  ex_ctrl_t        ex_q;
  logic            stk_push;
  logic            stk_pop;
  logic [PC_W-1:0] stk_top;
  logic            stk_full;
  logic            stk_empty;
  logic            unused_instr;

  // Only the opcode field and the jump-target field are meaningful here.
  assign unused_instr = ^id_instr;

  assign op6       = id_instr[INSTR_W-1 -: OP_W];
  assign is_arith  = ~op6[5];
  assign is_mem    = (op6[5:3] == OP3_MEM);
  assign is_shift  = (op6[5:3] == OP3_SHIFT);
  assign is_branch = (op6[5:3] == OP3_BRANCH);
  assign is_jmp    = (op6[5:1] == OP5_JMP);
  assign is_jsb    = (op6[5:1] == OP5_JSB);
  assign is_ret    = (op6 == OP6_RET);

  // The flags a branch reads are written at the end of the cycle in which the
  // producer sits in EX, so hold the branch exactly one cycle. The bubble
  // inserted behind it clears the condition on the next cycle.
  assign id_stall = id_valid & is_branch & (ex_q.write_c | ex_q.write_z);
  assign issue    = id_valid & ~id_stall;

  // op6[2] selects C vs Z, op6[1] inverts the sense.
  assign br_cond  = op6[2] ? flag_c : flag_z;
  assign br_taken = op6[1] ? ~br_cond : br_cond;

  always_comb begin
    pc_sel = PC_INC;
    if (issue) begin
      if (is_branch && br_taken) begin
        pc_sel = PC_BRANCH;
      end else if (is_jmp || is_jsb) begin
        pc_sel = PC_JUMP;
      end else if (is_ret) begin
        pc_sel = PC_RET;
      end
    end
  end

  assign pc_mux   = pc_sel;
  assign if_flush = (pc_sel != PC_INC);
  assign target   = (pc_sel == PC_RET) ? stk_top : id_instr[PC_W-1:0];
  assign stk_push = issue & is_jsb;
  assign stk_pop  = issue & is_ret;

  // Decoder. Bubbles, stalls and control-flow instructions all produce an
  // all-zero bundle.
  always_comb begin
    ex_d = '0;
    if (issue) begin
      if (is_arith) begin
        ex_d.reg_write     = 1'b1;
        ex_d.alu_in_mux    = {1'b0, op6[4]};
        ex_d.alu_op        = op6[3:1];
        ex_d.alu_use_carry = op6[1];
        ex_d.write_c       = 1'b1;
        ex_d.write_z       = 1'b1;
      end else if (is_mem) begin
        ex_d.reg_b_mux  = 1'b1;
        ex_d.alu_in_mux = AIN_MEM;
        if (op6[1]) begin
          ex_d.mem_write = 1'b1;
        end else begin
          ex_d.reg_write     = 1'b1;
          ex_d.reg_write_mux = WR_MEM;
        end
      end else if (is_shift) begin
        ex_d.reg_write     = 1'b1;
        ex_d.reg_write_mux = WR_SHIFT;
        ex_d.write_c       = 1'b1;
        ex_d.write_z       = 1'b1;
        ex_d.flag_sh       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  // Flags capture the EX-stage result of the instruction currently in EX.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else begin
      if (ex_q.write_c) begin
        flag_c <= ex_q.flag_sh ? sh_c : alu_c;
      end
      if (ex_q.write_z) begin
        flag_z <= ex_q.flag_sh ? sh_z : alu_z;
      end
    end
  end

  assign ex_mem_write     = ex_q.mem_write;
  assign ex_reg_write     = ex_q.reg_write;
  assign ex_reg_B_mux     = ex_q.reg_b_mux;
  assign ex_alu_use_carry = ex_q.alu_use_carry;
  assign ex_alu_op        = ex_q.alu_op;
  assign ex_alu_in_mux    = ex_q.alu_in_mux;
  assign ex_reg_write_mux = ex_q.reg_write_mux;

  pipelined_controller_return_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_W)
  ) u_ret_stack (
    .clk      (clk),
    .reset    (reset),
    .push     (stk_push),
    .push_dat (id_pc + PC_W'(1)),
    .pop      (stk_pop),
    .top      (stk_top),
    .full     (stk_full),
    .empty    (stk_empty),
    .ovf      (stk_ovf),
    .unf      (stk_unf)
  );

  // full/empty are consumed inside the stack; exported for visibility only.
  logic unused_stk;
  assign unused_stk = stk_full ^ stk_empty;

endmodule
